// File: rtl/cp0_intc.sv
// cp0_intc: MIPS-style CP0 interrupt/exception controller.
// Holds STATUS, CAUSE, EPC (and, with CP0_INTC_TIMER_EN defined, COUNT/COMPARE
// plus the timer flag on IP[7]). External lines are synchronised per line by
// an array of cp0_intc_sync instances before they reach CAUSE.IP.
// Build option: `define CP0_INTC_TIMER_EN to enable the COUNT/COMPARE timer.

// Per-line synchroniser: a short flop chain, cleared on reset.
module cp0_intc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_pipe;

    // Shift the asynchronous level through STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe[0] <= d;
            for (int k = 1; k < STAGES; k++) sync_pipe[k] <= sync_pipe[k-1];
        end
    end

    assign q = sync_pipe[STAGES-1];
endmodule

module cp0_intc #(
    parameter int N_INT       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [4:0]       waddr,
    input  logic [31:0]      wdata,
    input  logic [4:0]       raddr,
    output logic [31:0]      rdata,
    input  logic [N_INT-1:0] int_in,
    input  logic             exc_ovf,
    input  logic             exc_syscall,
    input  logic             exc_unknown,
    input  logic             eret,
    input  logic [31:0]      exc_pc,
    input  logic             exc_bd,
    output logic             exc_take,
    output logic [31:0]      exc_vec,
    output logic [31:0]      epc_out,
    output logic [31:0]      status_out,
    output logic [31:0]      cause_out,
    output logic             int_pending
);
    localparam logic [4:0]  REG_COUNT   = 5'd9;
    localparam logic [4:0]  REG_COMPARE = 5'd11;
    localparam logic [4:0]  REG_STATUS  = 5'd12;
    localparam logic [4:0]  REG_CAUSE   = 5'd13;
    localparam logic [4:0]  REG_EPC     = 5'd14;
    // IE, EXL, IM[7:0], BEV
    localparam logic [31:0] STATUS_MASK = 32'h0040_FF03;
    localparam logic [31:0] STATUS_RST  = 32'h0040_0000;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    logic [31:0]      status_q;
    logic [4:0]       exc_code_q;
    logic [1:0]       ip_sw_q;
    logic             iv_q;
    logic             bd_q;
    logic [31:0]      epc_q;
    logic [31:0]      count_q;
    logic [31:0]      compare_q;
    logic             timer_q;

    logic [N_INT-1:0] int_sync;
    logic [5:0]       sync_pad;
    logic [7:0]       ip;
    logic             int_sel;
    logic [4:0]       exc_code_nxt;
    logic [31:0]      vec_base;

    // One synchroniser per external line.
    cp0_intc_sync #(.STAGES(SYNC_STAGES)) u_sync [N_INT-1:0] (
        .clk (clk),
        .rst (rst),
        .d   (int_in),
        .q   (int_sync)
    );

    // Zero-pad so IP[7] only sees a sixth line when one exists.
    assign sync_pad = 6'(int_sync);
    assign ip       = {timer_q | sync_pad[5], sync_pad[4:0], ip_sw_q};

    assign int_pending = status_q[0] & ~status_q[1] & |(ip & status_q[15:8]);
    assign exc_take    = exc_ovf | exc_syscall | exc_unknown | int_pending;
    assign int_sel     = int_pending & ~exc_ovf;
    assign vec_base    = status_q[22] ? 32'hBFC0_0200 : 32'h8000_0000;
    assign exc_vec     = vec_base + ((int_sel & iv_q) ? 32'h0000_0200 : 32'h0000_0180);

    assign epc_out    = epc_q;
    assign status_out = status_q;
    assign cause_out  = {bd_q, 7'b0, iv_q, 7'b0, ip, 1'b0, exc_code_q, 2'b0};

    // Exception code by priority: overflow, interrupt, reserved instr, syscall.
    always_comb begin
        exc_code_nxt = EXC_SYS;
        if (exc_ovf)          exc_code_nxt = EXC_OV;
        else if (int_pending) exc_code_nxt = EXC_INT;
        else if (exc_unknown) exc_code_nxt = EXC_RI;
    end

    // STATUS/CAUSE/EPC: mtc0 first, exception entry overlays it, eret last.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
            iv_q       <= 1'b0;
            bd_q       <= 1'b0;
            epc_q      <= '0;
        end else begin
            if (we) begin
                case (waddr)
                    REG_STATUS: status_q <= wdata & STATUS_MASK;
                    REG_CAUSE: begin
                        ip_sw_q <= wdata[9:8];
                        iv_q    <= wdata[23];
                    end
                    REG_EPC:    epc_q <= wdata;
                    default: ;
                endcase
            end
            if (exc_take) begin
                status_q[1] <= 1'b1;
                exc_code_q  <= exc_code_nxt;
                // Nested exceptions keep the original return point.
                if (!status_q[1]) begin
                    epc_q <= exc_bd ? exc_pc - 32'd4 : exc_pc;
                    bd_q  <= exc_bd;
                end
            end else if (eret) begin
                status_q[1] <= 1'b0;
            end
        end
    end

`ifdef CP0_INTC_TIMER_EN
    // Free-running COUNT, COMPARE, and sticky match flag (COMPARE write wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            timer_q   <= 1'b0;
        end else begin
            count_q <= (we && waddr == REG_COUNT) ? wdata : count_q + 32'd1;
            if (we && waddr == REG_COMPARE) begin
                compare_q <= wdata;
                timer_q   <= 1'b0;
            end else if (count_q == compare_q) begin
                timer_q <= 1'b1;
            end
        end
    end
`else
    assign count_q   = '0;
    assign compare_q = '0;
    assign timer_q   = 1'b0;
`endif

    // mfc0 read mux; reflects state before the current edge.
    always_comb begin
        rdata = '0;
        case (raddr)
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = status_q;
            REG_CAUSE:   rdata = cause_out;
            REG_EPC:     rdata = epc_q;
            default:     rdata = '0;
        endcase
    end
endmodule

// File: doc/cp0_intc.md
CP0_INTC -- requirements
Module: cp0_intc

Interface
REQ-001 Parameter N_INT, default 5: external interrupt lines (1..6), mapped to CAUSE.IP[2+i].
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per external line (1..3).
REQ-003 Ports: clk in 1, system clock; rst in 1, reset; one clock, reset synchronous and active-high.
REQ-004 we in 1 (mtc0 write strobe); waddr in 5 (CP0 reg number); wdata in 32 (write data).
REQ-005 raddr in 5 (mfc0 select); rdata out 32 (combinational read of current register).
REQ-006 int_in in N_INT (asynchronous level interrupts); exc_ovf in 1; exc_syscall in 1; exc_unknown in 1; eret in 1.
REQ-007 exc_pc in 32 (PC of faulting/interrupted instruction); exc_bd in 1 (that instruction is in a delay slot).
REQ-008 exc_take out 1; exc_vec out 32; epc_out out 32; status_out out 32; cause_out out 32; int_pending out 1.

Function
REQ-009 Registers SHALL be: COUNT(9), COMPARE(11), STATUS(12), CAUSE(13), EPC(14); other raddr SHALL read 0, writes ignored.
REQ-010 STATUS writable bits SHALL be IE[0], EXL[1], IM[15:8], BEV[22]; all others read 0.
REQ-011 CAUSE SHALL hold ExcCode[6:2], IP[15:8], IV[23], BD[31]; only IP[9:8] and IV writable by mtc0; IP[7:2] read-only hardware.
REQ-012 IP[2+i] SHALL equal int_in[i] after SYNC_STAGES flops; IP[7] SHALL be timer flag OR (N_INT==6 ? synchronised int_in[5] : 0).
REQ-013 int_pending SHALL be IE & ~EXL & |(IP & IM), computed from registered state.
REQ-014 exc_take SHALL be combinational: exc_ovf | exc_syscall | exc_unknown | int_pending.
REQ-015 Priority SHALL be exc_ovf > interrupt > exc_unknown > exc_syscall; ExcCode 12, 0, 10, 8 respectively.
REQ-016 exc_vec SHALL be base + offset; base = BEV ? 32'hBFC0_0200 : 32'h8000_0000; offset = (interrupt selected & IV) ? 32'h200 : 32'h180.
REQ-017 On exc_take edge: ExcCode updated; if EXL was 0, EPC = exc_bd ? exc_pc-4 : exc_pc and BD = exc_bd; if EXL was 1, EPC and BD unchanged; EXL set to 1.
REQ-018 eret SHALL clear EXL on next edge; epc_out always reflects EPC; eret ignored when exc_take asserted same cycle.
REQ-019 mtc0 and exception in same cycle: mtc0 applied first, exception field updates (EXL, ExcCode, BD, EPC) overlay it.
REQ-020 COUNT SHALL increment by 1 each cycle, wrapping 32'hFFFF_FFFF -> 0; mtc0 to COUNT loads wdata with no increment that cycle.
REQ-021 Timer flag SHALL set (sticky) on the edge where COUNT == COMPARE; mtc0 to COMPARE clears it; set and clear same edge -> clear wins.
REQ-022 rdata, status_out, cause_out SHALL show register values before the current edge (no write bypass).

Reset
REQ-023 On rst: STATUS = 32'h0040_0000, CAUSE = 0, EPC = 0, COUNT = 0, COMPARE = 32'hFFFF_FFFF, timer flag 0, synchroniser flops 0.
REQ-024 rst overrides we, eret and exceptions in the same cycle; exc_take still reflects its combinational inputs.

Configuration
REQ-025 Macro CP0_INTC_TIMER_EN: defined -> COUNT/COMPARE and timer flag per REQ-020/021.
REQ-026 Undefined -> COUNT and COMPARE read 0, writes ignored, timer flag constant 0; IP[7] from int_in[5] only.

Verification
REQ-027 Reset, then mtc0 STATUS=32'h0000_0401, assert int_in[0] -> after SYNC_STAGES+1 edges int_pending=1, exc_take=1, exc_vec=32'h8000_0180.
REQ-028 EXL=0, exc_syscall with exc_pc=32'h100, exc_bd=1 -> EPC=32'hFC, BD=1, ExcCode=8, EXL=1; eret next cycle -> EXL=0, epc_out=32'hFC.
REQ-029 exc_ovf and exc_unknown same cycle, pc=32'h200 -> ExcCode=12, EPC=32'h200; second exc_syscall while EXL=1 -> EPC stays 32'h200, ExcCode=8.
REQ-030 COMPARE=10, COUNT=5, STATUS.IM[7]=1, IE=1 -> IP[7] sets at edge with COUNT==10; mtc0 COMPARE=50 -> IP[7]=0 next cycle.
REQ-031 BEV=1, IV=1, interrupt taken -> exc_vec=32'hBFC0_0400; same with exc_ovf -> exc_vec=32'hBFC0_0380.
